parity_frame_checker: RTL

- Receive-side counterpart of the team's 4-bit parity generator.
- Deserialises a framed serial stream (start, DATA_W data bits LSB first, parity bit, stop) sampled on a bit-enable strobe.
- Recomputes parity in the selected mode and flags parity and framing errors.
- Sits after the serial line sampler; presents each checked word to downstream logic with a one-cycle valid pulse.

---
 rtl/parity_pkg.sv | 23 ++
 rtl/parity_frame_checker.sv | 104 ++++++++++
 2 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / frame checker pair:
// FSM state encoding, parity mode constants and the common parity function.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Widest word the shared function accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int PARITY_MAX_W = 64;

  // Expected parity bit for a word: even mode gives ^word, odd mode gives ~^word.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] word, input logic mode);
    return (^word) ^ mode;
  endfunction

endpackage

// File: rtl/parity_frame_checker.sv
// Receive-side frame checker: deserialises start/data/parity/stop frames on bit_en,
// reports parity and framing errors and counts parity-error frames (saturating).
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              bit_en,
  input  logic              parity_mode,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error,
  output logic              busy,
  output logic [CNT_W-1:0]  parity_err_cnt
);

  localparam int BCNT_W = $clog2(DATA_W) + 1;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [BCNT_W-1:0]   r_bit_cnt;
  logic                r_mode_q;
  logic                r_p_rx;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_parity_error;
  logic                r_framing_error;
  logic                r_busy;
  logic [CNT_W-1:0]    r_parity_err_cnt;
  logic                w_perr;

  // Error for the frame being closed; only consumed in STOP, when r_shift holds the full word.
  assign w_perr = calc_parity({{(PARITY_MAX_W-DATA_W){1'b0}}, r_shift}, r_mode_q) != r_p_rx;

  // Frame FSM with shift register, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_shift          <= {DATA_W{1'b0}};
      r_bit_cnt        <= {BCNT_W{1'b0}};
      r_mode_q         <= 1'b0;
      r_p_rx           <= 1'b0;
      r_data_out       <= {DATA_W{1'b0}};
      r_data_valid     <= 1'b0;
      r_parity_error   <= 1'b0;
      r_framing_error  <= 1'b0;
      r_busy           <= 1'b0;
      r_parity_err_cnt <= {CNT_W{1'b0}};
    end else begin
      r_data_valid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (!serial_in) begin
              r_state   <= DATA;
              r_bit_cnt <= {BCNT_W{1'b0}};
              r_mode_q  <= parity_mode;
              r_busy    <= 1'b1;
            end
          end
          DATA: begin
            r_shift   <= {serial_in, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            if (r_bit_cnt == BCNT_W'(DATA_W - 1)) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_p_rx  <= serial_in;
            r_state <= STOP;
          end
          STOP: begin
            r_data_out      <= r_shift;
            r_data_valid    <= 1'b1;
            r_framing_error <= ~serial_in;
            r_parity_error  <= w_perr;
            if (w_perr && (r_parity_err_cnt != {CNT_W{1'b1}})) begin
              r_parity_err_cnt <= r_parity_err_cnt + CNT_W'(1);
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out       = r_data_out;
  assign data_valid     = r_data_valid;
  assign parity_error   = r_parity_error;
  assign framing_error  = r_framing_error;
  assign busy           = r_busy;
  assign parity_err_cnt = r_parity_err_cnt;

endmodule
